// File: rtl/lfsr_crypt_pkg.sv
// Shared types and constants for the LFSR stream-encryption datapath.
package lfsr_crypt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG_LEN,
    ST_CFG_TAP,
    ST_CFG_SEED,
    ST_PREAMBLE,
    ST_PAYLOAD,
    ST_DONE
  } crypt_state_t;

  localparam logic [7:0] PRE_CHAR = 8'h5F;

  localparam int unsigned CFG_OFS_LEN  = 0;
  localparam int unsigned CFG_OFS_TAP  = 1;
  localparam int unsigned CFG_OFS_SEED = 2;

endpackage

// File: rtl/lfsr_crypt_dp_if.sv
// Plaintext-in / ciphertext-out valid/ready bundle of the encryption datapath.
interface lfsr_crypt_dp_if #(
  parameter int unsigned DW = 8
);

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/lfsr_crypt_fifo.sv
// Synchronous plaintext FIFO; head is visible on rd_data while not empty.
module lfsr_crypt_fifo #(
  parameter int unsigned DW         = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] wr_data,
  input  logic          pop,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is fine when the same cycle frees a slot.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/lfsr_crypt_dp.sv
// LFSR stream-encryption datapath: ROM-configured preamble + FIFO payload packets.
// Define LFSR_CRYPT_PARITY_EN to replace the top data bit with even parity.
module lfsr_crypt_dp
  import lfsr_crypt_pkg::*;
#(
  parameter int unsigned DW         = 8,
  parameter int unsigned LFSR_W     = 5,
  parameter int unsigned AW         = 4,
  parameter int unsigned CFG_BASE   = 0,
  parameter int unsigned MSG_LEN    = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  lfsr_crypt_dp_if.slave  bus,
  output logic [AW-1:0]   rom_addr,
  input  logic [DW-1:0]   rom_data,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CW = $clog2(MSG_LEN + 1);

  crypt_state_t      state;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_inc;
  logic [CW-1:0]     pre_lim;
  logic [DW-1:0]     pre_len;
  logic [LFSR_W-1:0] taps;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_next;
  logic [LFSR_W-1:0] seed;
  logic [DW-1:0]     fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              hs;
  logic              last;
  logic [DW-1:0]     plain;
  logic [DW-1:0]     cipher;

  lfsr_crypt_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (bus.in_valid && bus.in_ready),
    .wr_data (bus.in_data),
    .pop     ((state == ST_PAYLOAD) && hs),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.in_ready  = !fifo_full;
  assign bus.out_valid = (state == ST_PREAMBLE) || ((state == ST_PAYLOAD) && !fifo_empty);
  assign bus.out_data  = cipher;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);

  assign hs        = bus.out_valid && bus.out_ready;
  assign count_inc = count + CW'(1);
  assign last      = (count_inc == CW'(MSG_LEN));
  // Preamble length is clamped so an oversize value yields an all-preamble packet.
  assign pre_lim   = (32'(pre_len) >= MSG_LEN) ? CW'(MSG_LEN) : CW'(pre_len);
  assign lfsr_next = {lfsr[LFSR_W-2:0], ^(lfsr & taps)};
  assign seed      = rom_data[LFSR_W-1:0];

  always_comb begin
    plain = '0;
    if (state == ST_PREAMBLE)     plain = DW'(PRE_CHAR);
    else if (state == ST_PAYLOAD) plain = fifo_head;
    cipher = plain;
    cipher[LFSR_W-1:0] = plain[LFSR_W-1:0] ^ lfsr;
`ifdef LFSR_CRYPT_PARITY_EN
    cipher[DW-1] = ^cipher[DW-2:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      lfsr     <= '0;
      pre_len  <= '0;
      taps     <= '0;
      rom_addr <= AW'(CFG_BASE);
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_CFG_LEN;
            count    <= '0;
            rom_addr <= AW'(CFG_BASE + CFG_OFS_LEN);
          end
        end
        ST_CFG_LEN: begin
          pre_len  <= rom_data;
          rom_addr <= AW'(CFG_BASE + CFG_OFS_TAP);
          state    <= ST_CFG_TAP;
        end
        ST_CFG_TAP: begin
          taps     <= rom_data[LFSR_W-1:0];
          rom_addr <= AW'(CFG_BASE + CFG_OFS_SEED);
          state    <= ST_CFG_SEED;
        end
        ST_CFG_SEED: begin
          // An all-zero LFSR would never leave zero, so force a live seed.
          lfsr     <= (seed == '0) ? LFSR_W'(1) : seed;
          rom_addr <= AW'(CFG_BASE);
          state    <= (pre_len != '0) ? ST_PREAMBLE : ST_PAYLOAD;
        end
        ST_PREAMBLE: begin
          if (hs) begin
            count <= count_inc;
            lfsr  <= lfsr_next;
            if (last)                    state <= ST_DONE;
            else if (count_inc == pre_lim) state <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (hs) begin
            count <= count_inc;
            lfsr  <= lfsr_next;
            if (last) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          count <= '0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_crypt_dp.sv
// Self-checking bench for lfsr_crypt_dp against a packet-level reference model.
`timescale 1ns/1ps
module tb_lfsr_crypt_dp;

  localparam int DW         = 8;
  localparam int LFSR_W     = 5;
  localparam int AW         = 4;
  localparam int CFG_BASE   = 0;
  localparam int MSG_LEN    = 32;
  localparam int FIFO_DEPTH = 8;

  typedef logic [7:0] byte_q_t [$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          busy;
  logic          done;
  logic [7:0]    rom [16];

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;
  int gap_pct = 0;
  int done_cnt = 0;
  int push_cnt = 0;
  byte_q_t feed_q;
  byte_q_t got_q;

  lfsr_crypt_dp_if #(.DW(DW)) bus ();

  lfsr_crypt_dp #(
    .DW(DW), .LFSR_W(LFSR_W), .AW(AW), .CFG_BASE(CFG_BASE),
    .MSG_LEN(MSG_LEN), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  // Consumer: always ready, toggling, or random.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Producer: offers the head of feed_q with random gaps.
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (feed_q.size() != 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
        bus.in_valid = 1'b1;
        bus.in_data  = feed_q[0];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
  end

  // Mid-cycle monitor of handshakes that complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      if (bus.in_valid && bus.in_ready && feed_q.size() != 0) begin
        void'(feed_q.pop_front());
        push_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  function automatic logic [7:0] fix(logic [7:0] b);
    logic [7:0] r;
    r = b;
`ifdef LFSR_CRYPT_PARITY_EN
    r[7] = ^r[6:0];
`endif
    return r;
  endfunction

  // Whole-packet reference: byte i is plaintext XOR the LFSR after i steps.
  function automatic byte_q_t model_packet(int plen, logic [4:0] taps, logic [4:0] seed, byte_q_t pay);
    byte_q_t r;
    int s;
    int npre;
    int p;
    s    = (seed == 5'd0) ? 1 : int'(seed);
    npre = (plen < MSG_LEN) ? plen : MSG_LEN;
    for (int i = 0; i < MSG_LEN; i++) begin
      p = (i < npre) ? 32'h5F : int'(pay[i - npre]);
      r.push_back(fix(8'(p ^ s)));
      s = (s * 2) % 32 + ($countones(s & int'(taps)) % 2);
    end
    return r;
  endfunction

  function automatic byte_q_t rand_bytes(int n);
    byte_q_t r;
    for (int i = 0; i < n; i++) r.push_back(8'($urandom));
    return r;
  endfunction

  task automatic run_packet(output bit ok);
    int d0;
    d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    #1;
  endtask

  task automatic cmp_packet(string name, byte_q_t exp);
    checks++;
    if (got_q.size() !== MSG_LEN) begin errors++; $display("FAIL %s_len: got %0d want %0d", name, got_q.size(), MSG_LEN); end
    for (int i = 0; i < MSG_LEN; i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL %s_byte[%0d]: got %h want %h", name, i, got_q[i], exp[i]); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h want 00", bus.out_data); end
    checks++; if (rom_addr !== 4'(CFG_BASE)) begin errors++; $display("FAIL rst_rom_addr: got %h want %h", rom_addr, 4'(CFG_BASE)); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    byte_q_t pay;
    byte_q_t exp;
    bit ok;
    int d0;
    rom[0] = 8'd2; rom[1] = 8'h14; rom[2] = 8'h01;
    pay = rand_bytes(29);
    pay.push_front(8'h41);
    feed_q = pay; gap_pct = 0; ready_mode = 0;
    repeat (12) @(posedge clk);
    got_q.delete(); d0 = done_cnt;
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy: got %b want 1", busy); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_c1_valid: got %b want 0", bus.out_valid); end
    checks++; if (rom_addr !== 4'(CFG_BASE)) begin errors++; $display("FAIL lat_addr0: got %h want %h", rom_addr, 4'(CFG_BASE)); end
    @(negedge clk);
    checks++; if (rom_addr !== 4'(CFG_BASE + 1)) begin errors++; $display("FAIL lat_addr1: got %h want %h", rom_addr, 4'(CFG_BASE + 1)); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_c3_valid: got %b want 0", bus.out_valid); end
    checks++; if (rom_addr !== 4'(CFG_BASE + 2)) begin errors++; $display("FAIL lat_addr2: got %h want %h", rom_addr, 4'(CFG_BASE + 2)); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL lat_first_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.out_data !== fix(8'h5E)) begin errors++; $display("FAIL lat_first_data: got %h want %h", bus.out_data, fix(8'h5E)); end
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_done_timeout: got %b want 1", ok); end
    repeat (5) @(posedge clk);
    #1;
    exp = model_packet(2, 5'h14, 5'h01, pay);
    cmp_packet("basic", exp);
    checks++; if (got_q[1] !== fix(8'h5D)) begin errors++; $display("FAIL basic_pre2: got %h want %h", got_q[1], fix(8'h5D)); end
    checks++; if (got_q[2] !== fix(8'h45)) begin errors++; $display("FAIL basic_third: got %h want %h", got_q[2], fix(8'h45)); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_seed_zero();
    byte_q_t pay;
    byte_q_t exp;
    bit ok;
    rom[0] = 8'd1; rom[1] = 8'h14; rom[2] = 8'h00;
    pay = rand_bytes(31);
    feed_q = pay; gap_pct = 20; ready_mode = 0;
    got_q.delete();
    run_packet(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL seed0_timeout: got %b want 1", ok); end
    checks++; if (got_q[0] !== fix(8'h5E)) begin errors++; $display("FAIL seed0_first: got %h want %h", got_q[0], fix(8'h5E)); end
    exp = model_packet(1, 5'h14, 5'h00, pay);
    cmp_packet("seed0", exp);
  endtask

  task automatic test_reset_mid_payload();
    byte_q_t pay;
    byte_q_t exp;
    bit ok;
    int d0;
    rom[0] = 8'd2; rom[1] = 8'h14; rom[2] = 8'h01;
    pay = rand_bytes(30);
    feed_q = pay; gap_pct = 0; ready_mode = 0;
    got_q.delete(); d0 = done_cnt;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      if (got_q.size() >= 5) break;
    end
    #1 rst = 1'b1;
    feed_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b want 1", bus.in_ready); end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (done_cnt !== d0) begin errors++; $display("FAIL abort_done: got %0d want %0d", done_cnt, d0); end
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL abort_count: got %0d want 5", got_q.size()); end
    exp = model_packet(2, 5'h14, 5'h01, pay);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got_q[i] !== exp[i]) begin errors++; $display("FAIL abort_byte[%0d]: got %h want %h", i, got_q[i], exp[i]); end
    end
    // A fresh configuration proves the ROM is read again.
    rom[0] = 8'd3; rom[1] = 8'h12; rom[2] = 8'h07;
    pay = rand_bytes(29);
    feed_q = pay; gap_pct = 10;
    got_q.delete();
    run_packet(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL reread_timeout: got %b want 1", ok); end
    exp = model_packet(3, 5'h12, 5'h07, pay);
    cmp_packet("reread", exp);
  endtask

  task automatic test_long_preamble();
    byte_q_t pay;
    byte_q_t exp;
    bit ok;
    int p0;
    logic [4:0] taps;
    logic [4:0] seed;
    p0 = push_cnt;
    feed_q = rand_bytes(FIFO_DEPTH); gap_pct = 0;
    for (int c = 0; c < 100 && feed_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready: got %b want 0", bus.in_ready); end
    checks++; if (push_cnt - p0 !== FIFO_DEPTH) begin errors++; $display("FAIL full_pushes: got %0d want %0d", push_cnt - p0, FIFO_DEPTH); end
    @(posedge clk); #1;
    taps = 5'($urandom); seed = 5'($urandom);
    rom[0] = 8'd40; rom[1] = 8'(taps); rom[2] = 8'(seed);
    ready_mode = 2;
    got_q.delete();
    run_packet(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL longpre_timeout: got %b want 1", ok); end
    exp = model_packet(40, taps, seed, pay);
    cmp_packet("longpre", exp);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL longpre_no_pop: got %b want 0", bus.in_ready); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    byte_q_t pay;
    byte_q_t exp;
    logic [7:0] prev;
    logic [4:0] taps;
    logic [4:0] seed;
    bit prev_stall;
    bit seen_done;
    taps = 5'($urandom) | 5'h10; seed = 5'($urandom);
    rom[0] = 8'd1; rom[1] = 8'(taps); rom[2] = 8'(seed);
    pay = rand_bytes(31);
    got_q.delete();
    ready_mode = 1; gap_pct = 50;
    feed_q = pay;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    prev = '0; prev_stall = 1'b0; seen_done = 1'b0;
    for (int c = 0; c < 3000 && !seen_done; c++) begin
      @(negedge clk);
      if (prev_stall && bus.out_valid) begin
        checks++;
        if (bus.out_data !== prev) begin errors++; $display("FAIL stall_stable: got %h want %h", bus.out_data, prev); end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev = bus.out_data;
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b1) begin errors++; $display("FAIL bp_timeout: got %b want 1", seen_done); end
    @(posedge clk); #1;
    exp = model_packet(1, taps, seed, pay);
    cmp_packet("backpressure", exp);
  endtask

  task automatic test_random();
    int plens [4] = '{0, 4, 31, 32};
    byte_q_t pay;
    byte_q_t exp;
    bit ok;
    int npre;
    logic [4:0] taps;
    logic [4:0] seed;
    for (int k = 0; k < 4; k++) begin
      taps = 5'($urandom); seed = 5'($urandom);
      rom[0] = 8'(plens[k]); rom[1] = 8'(taps); rom[2] = 8'(seed);
      npre = (plens[k] < MSG_LEN) ? plens[k] : MSG_LEN;
      pay = rand_bytes(MSG_LEN - npre);
      ready_mode = 2; gap_pct = 30;
      feed_q = pay;
      got_q.delete();
      run_packet(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand%0d_timeout: got %b want 1", k, ok); end
      exp = model_packet(plens[k], taps, seed, pay);
      cmp_packet($sformatf("rand%0d", k), exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    test_reset();
    test_basic();
    test_seed_zero();
    test_reset_mid_payload();
    test_long_preamble();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lfsr_crypt_dp.md
Name: lfsr_crypt_dp

Overview:
Parametrised LFSR stream-encryption datapath with its own control FSM.
- On start, loads preamble length, taps and seed from an external combinational config ROM.
- Emits a fixed-length packet: preamble characters first, then payload bytes drawn from an internal input FIFO.
- Each byte's low LFSR_W bits are XORed with the LFSR state.
- Sits between the plaintext source (valid/ready) and the downstream consumer (valid/ready). Generalises the fixed 8-bit/5-bit/32-byte datapath in width, message length, config location and handshake.

Parameters:
DW, 8, data byte width (>= LFSR_W)
LFSR_W, 5, LFSR width; low LFSR_W bits of each byte are encrypted
AW, 4, config ROM address width
CFG_BASE, 0, ROM address of the preamble-length word (taps at +1, seed at +2)
MSG_LEN, 32, total bytes per packet, preamble included (>= 1)
FIFO_DEPTH, 8, input FIFO entries (power of two, >= 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a packet; sampled only in IDLE
in_data  in  DW  plaintext byte
in_valid  in  1  plaintext valid
in_ready  out  1  FIFO not full
rom_addr  out  AW  config ROM read address (registered)
rom_data  in  DW  config ROM data, combinational from rom_addr
out_data  out  DW  encrypted byte
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
busy  out  1  FSM not in IDLE
done  out  1  one-cycle pulse after the last byte handshake

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM goes to IDLE; FIFO flushes; byte counter = 0; LFSR = 0; config registers = 0.
  - rom_addr = CFG_BASE.
  - Outputs: out_valid=0, busy=0, done=0, in_ready=1, out_data=0.
  - Reset mid-packet aborts the packet; no done pulse.
- FIFO:
  - Push when in_valid && in_ready. Pop on a payload output handshake.
  - Simultaneous push/pop when full is allowed: count unchanged.
  - Push is accepted in any state except during reset.
- FSM states: IDLE, CFG_LEN, CFG_TAP, CFG_SEED, PREAMBLE, PAYLOAD, DONE.
  - IDLE: start=1 -> CFG_LEN. start is ignored in all other states.
  - CFG_LEN: rom_addr=CFG_BASE; latch pre_len=rom_data -> CFG_TAP.
  - CFG_TAP: rom_addr=CFG_BASE+1; latch taps=rom_data[LFSR_W-1:0] -> CFG_SEED.
  - CFG_SEED: rom_addr=CFG_BASE+2; load LFSR=rom_data[LFSR_W-1:0]. A zero seed is replaced by 1 (lock-up avoidance).
    - Next state PREAMBLE if pre_len != 0, else PAYLOAD.
  - PREAMBLE: out_valid=1 with plaintext PRE_CHAR. On handshake, count++.
    - Leave to PAYLOAD when count+1 == min(pre_len, MSG_LEN).
    - Leave to DONE when the handshaked byte is byte MSG_LEN.
  - PAYLOAD: out_valid = FIFO not empty; plaintext = FIFO head. On handshake: pop, count++. Last byte -> DONE.
  - DONE: done=1 for one cycle, count cleared -> IDLE.
- Config latency: 3 cycles from start to the first out_valid. No ROM reads occur outside the CFG states.
- Encryption (combinational on registered state):
  - out_data = {plain[DW-1:LFSR_W], plain[LFSR_W-1:0] ^ lfsr}.
  - out_data is held stable while out_valid && !out_ready.
- LFSR: advances only on an output handshake.
  - next = {lfsr[LFSR_W-2:0], ^(lfsr & taps)}.
  - Taps of 0 are legal and yield a shift-in of 0.
- Counter: width $clog2(MSG_LEN+1); never exceeds MSG_LEN.
- pre_len >= MSG_LEN: the packet is entirely preamble.

Optional Feature:
- Macro: LFSR_CRYPT_PARITY_EN.
- Defined: out_data[DW-1] is replaced by even parity of out_data[DW-2:0]. Requires DW > LFSR_W+1.
- Undefined: bit DW-1 passes through unmodified.

Decomposition:
- Package lfsr_crypt_pkg:
  - State enum crypt_state_t.
  - Constant PRE_CHAR = 8'h5F, zero-extended or truncated to DW.
  - Config offset constants CFG_OFS_LEN=0, CFG_OFS_TAP=1, CFG_OFS_SEED=2.
- One sub-module: lfsr_crypt_fifo (sync FIFO, parameters DW and FIFO_DEPTH; push/pop/full/empty/rdDat).
- LFSR stays inline.

Test Plan:
- Reset mid-PAYLOAD (rst pulse after 5 bytes) -> out_valid=0, busy=0, in_ready=1 next cycle; no done; next start re-reads the ROM.
- ROM {len=2, taps=5'h14, seed=5'h01}, out_ready=1 -> out_valid in cycle 3 after start; preamble bytes 8'h5E, 8'h5D.
- Same config, FIFO preloaded with 8'h41 -> third byte 8'h45 (LFSR=5'h04). 32 handshakes total, then a single done pulse.
- Seed=0 in ROM -> first preamble byte 8'h5E (seed forced to 1).
- pre_len=40 with MSG_LEN=32 -> 32 preamble bytes, no FIFO pops, done.
- Backpressure: out_ready toggling 0/1 with FIFO initially empty -> out_data stable while stalled; LFSR advances only on handshakes; in_ready=0 after 8 pushes without pops.
